nx_fifo_wr_arb: RTL

NX_FIFO_WR_ARB -- requirements
Module: nx_fifo_wr_arb

---
 rtl/nx_fifo_arb_pkg.sv | 13 +
 rtl/nx_rr_pick.sv | 28 ++
 rtl/nx_fifo_wr_arb.sv | 107 ++++++++++
 3 files changed

// File: rtl/nx_fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-side arbiter and its
// future read-side siblings.
package nx_fifo_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    // One registered write may still be in flight when a beat is accepted.
    localparam int SLOT_AVAIL_MIN = 2;

endpackage

// File: rtl/nx_rr_pick.sv
// Combinational round-robin picker: first set bit of req searching upward
// from ptr+1, wrapping at N-1.
module nx_rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          hit,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] cand;

    always_comb begin
        hit  = 1'b0;
        idx  = '0;
        cand = ptr;
        for (int k = 0; k < N; k++) begin
            cand = (cand == IW'(N - 1)) ? '0 : cand + 1'b1;
            if (!hit && req[cand]) begin
                hit = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/nx_fifo_wr_arb.sv
// Packet-locking round-robin arbiter that feeds the write port of the
// shared 1r1w RAM FIFO.
//
//   state | meaning
//   IDLE  | no owner; round-robin pick, no beats accepted (one-cycle bubble)
//   LOCK  | grant_id owns the FIFO until its eop beat is accepted or flush
module nx_fifo_wr_arb
    import nx_fifo_arb_pkg::*;
#(
    parameter  int N_REQ  = 4,
    parameter  int WIDTH  = 83,
    parameter  int SLOT_W = 8,
    localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    input  logic [N_REQ-1:0]       req_eop,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   fifo_wen,
    output logic [WIDTH-1:0]       fifo_wdata,
    input  logic [SLOT_W-1:0]      fifo_free_slots,
    input  logic                   fifo_overflow,
    input  logic                   flush,
    output logic [ID_W-1:0]        grant_id,
    output logic                   busy,
    output logic                   err_overflow
);

    arb_state_t state, state_nxt;
    logic [ID_W-1:0]  rr_ptr;
    logic             pick_hit;
    logic [ID_W-1:0]  pick_idx;
    logic             slot_avail;
    logic             accept;
    logic             owner_eop;
    logic [WIDTH-1:0] owner_data;

    nx_rr_pick #(
        .N  (N_REQ),
        .IW (ID_W)
    ) u_rr_pick (
        .req (req_valid),
        .ptr (rr_ptr),
        .hit (pick_hit),
        .idx (pick_idx)
    );

    assign slot_avail = (fifo_free_slots >= SLOT_W'(SLOT_AVAIL_MIN)) ||
                        ((fifo_free_slots == SLOT_W'(1)) && !fifo_wen);
    assign owner_eop  = req_eop[grant_id];
    assign owner_data = req_data[int'(grant_id)*WIDTH +: WIDTH];
    assign busy       = (state == LOCK);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (!flush && pick_hit) state_nxt = LOCK;
            LOCK: if (flush || (accept && owner_eop)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Gating with rst keeps a handshake from completing on a dropped beat.
    always_comb begin
        req_ready = '0;
        accept    = 1'b0;
        if ((state == LOCK) && !flush && !rst && slot_avail) begin
            req_ready[grant_id] = 1'b1;
            accept              = req_valid[grant_id];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr       <= ID_W'(N_REQ - 1);
            grant_id     <= '0;
            fifo_wen     <= 1'b0;
            fifo_wdata   <= '0;
            err_overflow <= 1'b0;
        end else begin
            fifo_wen <= accept;
            if (accept) begin
                fifo_wdata <= owner_data;
            end
            if (fifo_overflow) begin
                err_overflow <= 1'b1;
            end
            if ((state == IDLE) && !flush && pick_hit) begin
                grant_id <= pick_idx;
            end
            if (accept && owner_eop) begin
                rr_ptr <= grant_id;
            end
        end
    end

endmodule
